// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier slice.
package mult_seq_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned P_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step order: lo*lo, lo*hi, hi*lo, hi*hi
    localparam logic [3:0] SHIFT_TAB [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

    function automatic logic [P_W-1:0] shift_pp(input logic [2*NIB_W-1:0] pp,
                                                 input logic [1:0]         step);
        return P_W'(pp) << SHIFT_TAB[step];
    endfunction

endpackage

// File: rtl/mult4_core.sv
// 4x4 combinational multiplier core; VARIANT selects the generated implementation.
module mult4_core #(
    parameter int unsigned VARIANT = 0
) (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);

    if (VARIANT == 0) begin : g_exact
        always_comb P = A * B;
    end else if (VARIANT == 1) begin : g_trunc
        // Approximate variant: the A[0]*B[0] partial term is dropped.
        always_comb P = (A * B) - {7'd0, A[0] & B[0]};
    end else begin : g_bad_variant
        $error("mult4_core: unsupported VARIANT");
    end

endmodule

// File: rtl/mult8_seq_accum.sv
// Sequential 8x8 unsigned multiplier: four nibble products from one shared 4x4 core,
// shifted and accumulated. Optional zero-operand shortcut: MULT8_SEQ_ZERO_BYPASS_EN.
module mult8_seq_accum
    import mult_seq_pkg::*;
#(
    parameter int unsigned CORE_LAT     = 0,
    parameter int unsigned CORE_VARIANT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  out_p,
    output logic            busy
);

    if (CORE_LAT != 0) begin : g_core_lat_check
        $error("mult8_seq_accum: only CORE_LAT=0 is supported");
    end

    state_t             state;
    logic [1:0]         idx;
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [P_W-1:0]     acc;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [2*NIB_W-1:0] pp;
    logic [P_W-1:0]     acc_next;
    logic               zero_op;

    // idx[1] picks the a nibble, idx[0] the b nibble, matching SHIFT_TAB order.
    always_comb begin
        nib_a    = idx[1] ? a_q[7:4] : a_q[3:0];
        nib_b    = idx[0] ? b_q[7:4] : b_q[3:0];
        acc_next = acc + shift_pp(pp, idx);
    end

    mult4_core #(
        .VARIANT(CORE_VARIANT)
    ) u_core (
        .A(nib_a),
        .B(nib_b),
        .P(pp)
    );

`ifdef MULT8_SEQ_ZERO_BYPASS_EN
    always_comb zero_op = (in_a == '0) || (in_b == '0);
`else
    always_comb zero_op = 1'b0;
`endif

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            out_p <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        b_q <= in_b;
                        acc <= '0;
                        idx <= '0;
                        if (zero_op) begin
                            out_p <= '0;
                            state <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        out_p <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_accum.sv
// Self-checking bench for mult8_seq_accum: vector table, directed corner sequences,
// and randomized operands checked against plain a*b with the latency rule.
module tb_mult8_seq_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef MULT8_SEQ_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    mult8_seq_accum #(
        .CORE_LAT(0),
        .CORE_VARIANT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p(out_p),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle offset (accept edge = T) at which out_valid first appears.
    function automatic int exp_valid_cycle(input logic [7:0] a, input logic [7:0] b);
        if (BYPASS && (a == 8'd0 || b == 8'd0)) return 1;
        return 5;
    endfunction

    task automatic wait_ready(output bit ok);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        ok = in_ready;
    endtask

    // One full transaction. Inputs change only #1 after a rising edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                          input bit noise, output logic [15:0] p, output int vcyc,
                          output bit saw_ready);
        bit ok;
        wait_ready(ok);
        if (!ok) begin
            check("timeout_in_ready", 32'd0, 32'd1);
            p = 'x; vcyc = -1; saw_ready = 1'b1;
            return;
        end
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
        saw_ready = 1'b0;
        vcyc = 1;
        while (!out_valid && vcyc < 20) begin
            if (in_ready) saw_ready = 1'b1;
            if (noise) begin
                in_valid  = 1'($urandom);
                in_a      = 8'($urandom);
                in_b      = 8'($urandom);
                out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            vcyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) begin
            check("timeout_out_valid", 32'd0, 32'd1);
            vcyc = -1;
        end
        p = out_p;
        repeat (hold) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
        end
        if (in_ready) saw_ready = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] p;
        int          vcyc;
        bit          saw;
        bit          ok;
        int          seen;

        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{8'h12, 8'h34, 16'h03A8};
        vecs[2] = '{8'd3,  8'd5,  16'd15};
        vecs[3] = '{8'd200, 8'd100, 16'd20000};
        vecs[4] = '{8'h00, 8'h77, 16'h0000};
        vecs[5] = '{8'h01, 8'h01, 16'h0001};
        vecs[6] = '{8'h80, 8'h02, 16'h0100};
        vecs[7] = '{8'h0F, 8'hF0, 16'h0E10};
        vecs[8] = '{8'hF0, 8'hF0, 16'hE100};
        vecs[9] = '{8'h5A, 8'h00, 16'h0000};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_p", 32'(out_p), 32'd0);
        check("reset_in_ready_during_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 0, 1'b0, p, vcyc, saw);
            check($sformatf("vec%0d_p", i), 32'(p), 32'(vecs[i].p));
            check($sformatf("vec%0d_valid_cycle", i), 32'(vcyc),
                  32'(exp_valid_cycle(vecs[i].a, vecs[i].b)));
            check($sformatf("vec%0d_in_ready_low", i), 32'(saw), 32'd0);
        end

        // Backpressure: product must hold for 10 cycles with out_ready low.
        wait_ready(ok);
        in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vcyc = 0;
        while (!out_valid && vcyc < 20) begin
            @(posedge clk); #1;
            vcyc++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_p", 32'(out_p), 32'h03A8);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_exit_out_valid", 32'(out_valid), 32'd0);
        check("bp_exit_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back with in_valid held high across both operations.
        in_a = 8'd3; in_b = 8'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_a = 8'd200; in_b = 8'd100;
        vcyc = 0;
        while (!out_valid && vcyc < 20) begin
            @(posedge clk); #1;
            vcyc++;
        end
        check("b2b_first_p", 32'(out_p), 32'd15);
        @(posedge clk); #1;
        check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        vcyc = 0;
        while (!out_valid && vcyc < 20) begin
            @(posedge clk); #1;
            vcyc++;
        end
        check("b2b_second_p", 32'(out_p), 32'd20000);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_no_third", 32'(busy), 32'd0);

        // Reset in the middle of MUL discards the operation.
        wait_ready(ok);
        in_a = 8'hAB; in_b = 8'hCD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_out_p", 32'(out_p), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_mid_no_output", 32'(seen), 32'd0);

        // Randomized pairs, with noise on in_valid/out_ready while busy.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            if (n % 50 == 0) a = 8'd0;
            run_op(a, b, int'($urandom_range(0, 2)), 1'(n % 2), p, vcyc, saw);
            check("rand_p", 32'(p), 32'(a) * 32'(b));
            check("rand_valid_cycle", 32'(vcyc), 32'(exp_valid_cycle(a, b)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
